// File: rtl/req_arbiter3.sv
// req_arbiter3: three-way arbiter for one shared resource.
//
// One requester at a time is granted the resource. The grant is a registered
// one-hot vector and is held until the resource pulses done, the granted
// requester withdraws its request, or the watchdog expires. Every release is
// followed by exactly one RECOVER cycle with no grant before the next winner
// is chosen. While no grant is active, gnt_id keeps the last winner.
//
// Handshake: req[i] is a level "valid" from requester i. gnt[i] is the
// registered "ready/owner" answer, one cycle after arbitration. The pair is
// complete when the resource pulses done, or when req[i] falls while gnt[i]
// is high. A requester must keep req[i] high until it has been served.
//
// Build option: define ARB_ROUND_ROBIN_EN to rotate priority. The last
// winner then becomes the lowest priority. Without it, priority is fixed at
// 2 > 1 > 0.
//
// TIMEOUT sets the longest BUSY stretch before a forced release. 0 turns
// the watchdog off. dbg_state mirrors the FSM state so checkers can bind to it.

module req_arbiter3 #(
  parameter int TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] dbg_state
);

  // The timer only has to reach TIMEOUT-1. Keep it at least one bit wide.
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t          r_state;
  logic [2:0]      r_gnt;
  logic [1:0]      r_gnt_id;
  logic            r_busy;
  logic            r_timeout;
  logic [TW-1:0]   r_timer;

  logic            w_win_valid;
  logic [1:0]      w_win_id;
  logic            w_wdog_expire;
  logic            w_owner_left;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0]      r_rr_ptr;
  logic [1:0]      w_rr_c0;
  logic [1:0]      w_rr_c1;
  logic [1:0]      w_rr_c2;
`endif

  // Choose the winner among the current requests. Used only in IDLE and RECOVER.
  always_comb begin : arb_decode
    w_win_valid = 1'b0;
    w_win_id    = 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
    // Visit the slots in order, starting just after the last winner and wrapping.
    w_rr_c0 = (r_rr_ptr == 2'd2) ? 2'd0 : r_rr_ptr + 2'd1;
    w_rr_c1 = (w_rr_c0  == 2'd2) ? 2'd0 : w_rr_c0  + 2'd1;
    w_rr_c2 = (w_rr_c1  == 2'd2) ? 2'd0 : w_rr_c1  + 2'd1;
    if (req[w_rr_c0]) begin
      w_win_valid = 1'b1;
      w_win_id    = w_rr_c0;
    end else if (req[w_rr_c1]) begin
      w_win_valid = 1'b1;
      w_win_id    = w_rr_c1;
    end else if (req[w_rr_c2]) begin
      w_win_valid = 1'b1;
      w_win_id    = w_rr_c2;
    end
`else
    casez (req)
      3'b1??: begin
        w_win_valid = 1'b1;
        w_win_id    = 2'd2;
      end
      3'b01?: begin
        w_win_valid = 1'b1;
        w_win_id    = 2'd1;
      end
      3'b001: begin
        w_win_valid = 1'b1;
        w_win_id    = 2'd0;
      end
      default: begin
        w_win_valid = 1'b0;
        w_win_id    = 2'd0;
      end
    endcase
`endif
  end

  // Release conditions evaluated while BUSY.
  always_comb begin : busy_release
    w_owner_left  = ~req[r_gnt_id];
    w_wdog_expire = (TIMEOUT != 0) && (r_timer == TW'(TLAST));
  end

  // Main FSM. All outputs, the watchdog timer and the rotation pointer are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 3'b000;
      r_gnt_id  <= 2'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_timer   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_ptr  <= 2'd2;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RECOVER: begin
          // done has no effect here. Only the requests matter.
          if (w_win_valid) begin
            r_state  <= ST_BUSY;
            r_gnt    <= 3'b001 << w_win_id;
            r_gnt_id <= w_win_id;
            r_busy   <= 1'b1;
            r_timer  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_ptr <= w_win_id;
`endif
          end else begin
            r_state <= ST_IDLE;
            r_gnt   <= 3'b000;
            r_busy  <= 1'b0;
          end
        end

        ST_BUSY: begin
          if (done || w_owner_left) begin
            // A normal completion or a withdrawn request wins over the watchdog.
            r_state <= ST_RECOVER;
            r_gnt   <= 3'b000;
            r_busy  <= 1'b1;
          end else if (w_wdog_expire) begin
            r_state   <= ST_RECOVER;
            r_gnt     <= 3'b000;
            r_busy    <= 1'b1;
            r_timeout <= 1'b1;
          end else if (r_timer != {TW{1'b1}}) begin
            // Count up while the grant is held. Stop at the top value instead of wrapping.
            r_timer <= r_timer + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 3'b000;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign busy      = r_busy;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule
